// File: rtl/cmos_frame_capture_ctrl_if.sv
// Camera byte stream, capture control, packed-word write port and status of the
// CMOS frame capture controller, bundled for connection between producer and block.
`timescale 1ns/1ps
interface cmos_frame_capture_ctrl_if;
    logic        cmos_frame_vsync;
    logic        cmos_frame_href;
    logic        cmos_frame_clken;
    logic [7:0]  cmos_frame_data;
    logic        cap_start;
    logic        cap_cont;
    logic        cap_stop;
    logic        wr_full;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        buf_sel;
    logic        busy;
    logic        frame_done;
    logic        ovf_err;
    logic        size_err;
    logic [7:0]  frame_cnt;

    modport master (
        output cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
        output cap_start, cap_cont, cap_stop, wr_full,
        input  wr_en, wr_data, buf_sel, busy, frame_done, ovf_err, size_err, frame_cnt
    );

    modport slave (
        input  cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
        input  cap_start, cap_cont, cap_stop, wr_full,
        output wr_en, wr_data, buf_sel, busy, frame_done, ovf_err, size_err, frame_cnt
    );
endinterface

// File: rtl/cmos_frame_capture_ctrl.sv
// Captures whole CMOS frames, packs byte pairs into 16-bit words for a write FIFO,
// supports single-shot and continuous ping-pong capture with sticky error flags.
`timescale 1ns/1ps
module cmos_frame_capture_ctrl #(
    parameter int IMG_H = 640,
    parameter int IMG_V = 480
) (
    input logic                      cmos_pclk,
    input logic                      rst,
    cmos_frame_capture_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

    localparam logic [11:0] LINE_BYTES  = 12'(2 * IMG_H);
    localparam logic [9:0]  FRAME_LINES = 10'(IMG_V);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic        stop_q, stop_d;
    logic        vs_prev_q, hr_prev_q;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        buf_sel_q, buf_sel_d;
    logic        ovf_q, ovf_d;
    logic        size_q, size_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        fdone;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    wire vs_rise  = !vs_prev_q &&  bus.cmos_frame_vsync;
    wire vs_fall  =  vs_prev_q && !bus.cmos_frame_vsync;
    wire hr_rise  = !hr_prev_q &&  bus.cmos_frame_href;
    wire hr_fall  =  hr_prev_q && !bus.cmos_frame_href;
    wire byte_vld =  bus.cmos_frame_href && bus.cmos_frame_clken;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stop_d      = stop_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        byte_cnt_d  = byte_cnt_q;
        line_cnt_d  = line_cnt_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        buf_sel_d   = buf_sel_q;
        ovf_d       = ovf_q;
        size_d      = size_q;
        frame_cnt_d = frame_cnt_q;
        fdone       = 1'b0;

        if (hr_rise) byte_cnt_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.cap_start) begin
                    state_d = WAIT_SOF;
                    mode_d  = bus.cap_cont;
                    ovf_d   = 1'b0;
                    size_d  = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            WAIT_SOF: begin
                if (bus.cap_stop) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end else if (vs_rise) begin
                    state_d    = CAPTURE;
                    line_cnt_d = '0;
                    phase_d    = 1'b0;
                end
            end
            CAPTURE: begin
                if (byte_vld) begin
                    byte_cnt_d = sat_inc12(byte_cnt_d);
                    if (!phase_q) begin
                        hi_d    = bus.cmos_frame_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // A word meeting a full FIFO is lost, not retried
                        if (bus.wr_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {hi_q, bus.cmos_frame_data};
                        end
                    end
                end
                if (hr_fall) begin
                    if (byte_cnt_q != LINE_BYTES) size_d = 1'b1;
                    phase_d    = 1'b0;
                    line_cnt_d = sat_inc10(line_cnt_q);
                end
                if (bus.cap_stop) stop_d = 1'b1;
                if (vs_fall) begin
                    fdone       = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    wr_en_d     = 1'b0;
                    if (line_cnt_d != FRAME_LINES) size_d = 1'b1;
                    if (mode_q && !stop_d) begin
                        state_d   = WAIT_SOF;
                        buf_sel_d = ~buf_sel_q;
                    end else begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            stop_q      <= 1'b0;
            vs_prev_q   <= 1'b0;
            hr_prev_q   <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            byte_cnt_q  <= '0;
            line_cnt_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            buf_sel_q   <= 1'b0;
            ovf_q       <= 1'b0;
            size_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stop_q      <= stop_d;
            vs_prev_q   <= bus.cmos_frame_vsync;
            hr_prev_q   <= bus.cmos_frame_href;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            byte_cnt_q  <= byte_cnt_d;
            line_cnt_q  <= line_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            buf_sel_q   <= buf_sel_d;
            ovf_q       <= ovf_d;
            size_q      <= size_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.buf_sel    = buf_sel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = fdone;
    assign bus.ovf_err    = ovf_q;
    assign bus.size_err   = size_q;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: doc/cmos_frame_capture_ctrl.md
CMOS_FRAME_CAPTURE_CTRL -- requirements
Module: cmos_frame_capture_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_H, default 640, meaning pixels per line, with 2 bytes per pixel.
REQ-002 The block SHALL have parameter IMG_V, default 480, meaning lines per frame.
REQ-003 The block SHALL have port cmos_pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port cmos_frame_vsync, input, 1 bit: frame valid, high for the whole frame.
REQ-006 The block SHALL have port cmos_frame_href, input, 1 bit: line valid.
REQ-007 The block SHALL have port cmos_frame_clken, input, 1 bit: byte valid strobe.
REQ-008 The block SHALL have port cmos_frame_data, input, 8 bits: byte data.
REQ-009 The block SHALL have port cap_start, input, 1 bit: single-cycle pulse that arms capture.
REQ-010 The block SHALL have port cap_cont, input, 1 bit: continuous mode, sampled at cap_start.
REQ-011 The block SHALL have port cap_stop, input, 1 bit: pulse requesting stop after the current frame.
REQ-012 The block SHALL have port wr_full, input, 1 bit: downstream write FIFO full.
REQ-013 The block SHALL have port wr_en, output, 1 bit: write strobe.
REQ-014 The block SHALL have port wr_data, output, 16 bits: packed pixel word.
REQ-015 The block SHALL have port buf_sel, output, 1 bit: ping-pong frame buffer currently being written.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of each captured frame.
REQ-018 The block SHALL have the following sticky outputs, each 1 bit: ovf_err (word dropped on full), size_err (line or frame size mismatch).
REQ-019 The block SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-020 States SHALL be IDLE, WAIT_SOF and CAPTURE.
- IDLE->WAIT_SOF on cap_start; the block latches cap_cont into a mode register and clears ovf_err and size_err.
REQ-021 In WAIT_SOF, a vsync rising edge (registered previous value 0, current value 1) SHALL move the state to CAPTURE.
- Entering CAPTURE from WAIT_SOF mid-frame is impossible, because the edge is required.
REQ-022 In CAPTURE, a vsync falling edge SHALL:
- pulse frame_done for 1 cycle in the edge-detect cycle;
- increment frame_cnt, wrapping 255->0;
- check the line count: if lines != IMG_V, set size_err.
REQ-023 After a frame end, the next state SHALL be:
- WAIT_SOF with buf_sel toggled, if the mode register is 1 and no stop is pending;
- IDLE otherwise, with buf_sel unchanged.
REQ-024 cap_start SHALL be ignored when busy=1.
- cap_stop in WAIT_SOF goes to IDLE on the next cycle with no frame_done.
- cap_stop in CAPTURE sets a stop-pending flag, which is cleared on entry to IDLE.
- cap_stop in IDLE is ignored.
REQ-025 Byte packing (CAPTURE only) SHALL work as follows:
- each clken=1 byte toggles a phase bit;
- the phase-0 byte goes to wr_data[15:8];
- the phase-1 byte completes the word with wr_data[7:0].
REQ-026 A word SHALL be issued as follows:
- wr_en=1 for exactly 1 cycle, in the cycle after the phase-1 byte, with wr_data stable in that cycle;
- wr_en SHALL never assert outside CAPTURE.
REQ-027 If wr_full=1 in the cycle a word completes, the word SHALL be dropped: wr_en stays 0 and ovf_err is set.
- There is no retry or buffering; the next word proceeds normally.
REQ-028 Line and pixel accounting SHALL work as follows:
- a per-line byte counter (12 bits, saturating) clears on href rising edge;
- on href falling edge, if bytes != 2*IMG_H, size_err is set (this includes an odd trailing byte, which is discarded);
- on href falling edge, the phase resets to 0 and the line counter (10 bits, saturating) increments;
- the line counter clears on entry to CAPTURE.
REQ-029 When vsync rise and fall edges are detected in the same state, edge handling SHALL use only the registered previous vsync.
- Back-to-back frames SHALL be captured if the rise of frame N+1 arrives at least 1 cycle after frame_done.
REQ-030 Bytes with href=0, or clken=1 outside CAPTURE, SHALL be ignored.

Reset
REQ-031 While rst=1, the block SHALL hold: state=IDLE, wr_en=0, wr_data=0, buf_sel=0, busy=0, frame_done=0, ovf_err=0, size_err=0, frame_cnt=0, all counters and edge registers 0.
REQ-032 Reset asserted mid-CAPTURE SHALL abort with no frame_done.
- After release, the block stays IDLE until cap_start.

Verification
REQ-033 Bench scenario, single frame (IMG_H=4, IMG_V=2): cap_start with cap_cont=0, then one 2x8-byte frame -> 8 wr_en pulses with correct byte order, frame_done once, frame_cnt=1, busy=0 afterwards, no errors.
REQ-034 Bench scenario, continuous: cap_cont=1, 3 frames, cap_stop during frame 3 -> 3 frame_done pulses, buf_sel sequence 0,1,0, IDLE after frame 3.
REQ-035 Bench scenario, backpressure: wr_full=1 for the 2nd word -> 7 wr_en pulses, ovf_err=1 sticky until the next cap_start.
REQ-036 Bench scenario, size errors:
- a 7-byte line -> size_err=1, odd byte discarded;
- separately, a 3-line frame -> size_err=1 at frame end.
REQ-037 Bench scenario, mid-frame arm: cap_start while vsync=1 -> no writes until the next vsync rise, then one full frame.
REQ-038 Bench scenario, reset mid-CAPTURE: rst pulse after 3 words -> all outputs at reset values, no frame_done, a new cap_start works normally.
